// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared parameters, types and saturating add for the sfu_accum stage
package sfu_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int N_OUT   = 16;
  localparam int N_KIJ   = 9;
  localparam int CNT_W   = 4;

  typedef logic signed [PSUM_BW-1:0] psum_t;
  typedef psum_t [COL-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WRITE,
    DONE
  } sfu_state_e;

  localparam psum_t PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] KIJ_LAST = CNT_W'(N_KIJ - 1);

  // Sign-extend to PSUM_BW+1 bits; the two top bits disagree only on overflow.
  function automatic psum_t sat_add(input psum_t a, input psum_t b);
    logic signed [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1]) begin
      sat_add = s[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
    end else begin
      sat_add = s[PSUM_BW-1:0];
    end
  endfunction

endpackage

// File: rtl/sfu_lane_sat.sv
// rtl/sfu_lane_sat.sv - combinational signed saturating adder for one psum lane
module sfu_lane_sat
  import sfu_pkg::*;
(
  input  psum_t i_a,
  input  psum_t i_b,
  output psum_t o_sum
);

  assign o_sum = sat_add(i_a, i_b);

endmodule

// File: rtl/sfu_accum.sv
// rtl/sfu_accum.sv - accumulates 9 kij psum passes into 16 rows, then writes them to output SRAM
// Optional SFU_RELU_EN: negative lanes are written as zero.
module sfu_accum
  import sfu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sfu_start,
  input  logic                     ofifo_valid,
  input  logic [COL*PSUM_BW-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     op_cen,
  output logic                     op_wen,
  output logic [CNT_W-1:0]         op_addr,
  output logic [COL*PSUM_BW-1:0]   op_d,
  output logic                     sfu_busy,
  output logic                     sfu_done
);

  sfu_state_e             r_state;
  logic [CNT_W-1:0]       r_kij_cnt;
  logic [CNT_W-1:0]       r_row_cnt;
  logic [CNT_W-1:0]       r_w_cnt;
  row_t                   r_acc [N_OUT];
  logic                   r_op_cen;
  logic                   r_op_wen;
  logic [CNT_W-1:0]       r_op_addr;
  row_t                   r_op_d;
  logic                   r_done;

  row_t                   w_in_row;
  row_t                   w_acc_row;
  row_t                   w_sum_row;
  row_t                   w_post_row;
  logic                   w_pop;

  function automatic row_t post_row(input row_t x);
    post_row = x;
`ifdef SFU_RELU_EN
    for (int c = 0; c < COL; c++) begin
      if (x[c][PSUM_BW-1]) post_row[c] = '0;
    end
`endif
  endfunction

  assign w_in_row   = ofifo_data;
  assign w_acc_row  = r_acc[r_row_cnt];
  assign w_post_row = post_row(r_acc[r_w_cnt]);
  assign w_pop      = (r_state == ACC) && ofifo_valid;

  for (genvar c = 0; c < COL; c++) begin : g_lane
    sfu_lane_sat u_sat (
      .i_a   (w_acc_row[c]),
      .i_b   (w_in_row[c]),
      .o_sum (w_sum_row[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_kij_cnt <= '0;
      r_row_cnt <= '0;
      r_w_cnt   <= '0;
      r_op_cen  <= 1'b1;
      r_op_wen  <= 1'b1;
      r_op_addr <= '0;
      r_op_d    <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sfu_start) begin
            r_state   <= ACC;
            r_kij_cnt <= '0;
            r_row_cnt <= '0;
          end
        end
        ACC: begin
          if (w_pop) begin
            // First kij pass overwrites, so stale rows from the last tile never leak in.
            r_acc[r_row_cnt] <= (r_kij_cnt == '0) ? w_in_row : w_sum_row;
            if (r_row_cnt == ROW_LAST) begin
              r_row_cnt <= '0;
              if (r_kij_cnt == KIJ_LAST) begin
                r_kij_cnt <= '0;
                r_w_cnt   <= '0;
                r_state   <= WRITE;
              end else begin
                r_kij_cnt <= r_kij_cnt + 1'b1;
              end
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          r_op_cen  <= 1'b0;
          r_op_wen  <= 1'b0;
          r_op_addr <= r_w_cnt;
          r_op_d    <= w_post_row;
          if (r_w_cnt == ROW_LAST) begin
            r_w_cnt <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_w_cnt <= r_w_cnt + 1'b1;
          end
        end
        DONE: begin
          // The last write is sampled by the SRAM at this edge; release the strobes afterwards.
          r_op_cen <= 1'b1;
          r_op_wen <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ofifo_rd = w_pop;
  assign op_cen   = r_op_cen;
  assign op_wen   = r_op_wen;
  assign op_addr  = r_op_addr;
  assign op_d     = r_op_d;
  assign sfu_busy = (r_state != IDLE);
  assign sfu_done = r_done;

endmodule

// File: tb/tb_sfu_accum.sv
// tb/tb_sfu_accum.sv - directed self-checking bench for sfu_accum
module tb_sfu_accum;

  logic         clk = 1'b0;
  logic         reset;
  logic         sfu_start;
  logic         ofifo_valid;
  logic [127:0] ofifo_data;
  logic         ofifo_rd;
  logic         op_cen;
  logic         op_wen;
  logic [3:0]   op_addr;
  logic [127:0] op_d;
  logic         sfu_busy;
  logic         sfu_done;

  int n_checks = 0;
  int n_fail   = 0;

  sfu_accum dut (
    .clk         (clk),
    .reset       (reset),
    .sfu_start   (sfu_start),
    .ofifo_valid (ofifo_valid),
    .ofifo_data  (ofifo_data),
    .ofifo_rd    (ofifo_rd),
    .op_cen      (op_cen),
    .op_wen      (op_wen),
    .op_addr     (op_addr),
    .op_d        (op_d),
    .sfu_busy    (sfu_busy),
    .sfu_done    (sfu_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane_in(input int mode, input int pop, input int lane);
    int row;
    row = pop % 16;
    case (mode)
      0: lane_in = 16'h0001;
      1: lane_in = (lane == 0) ? 16'h4000 : (lane == 1) ? 16'hC000 : 16'h0001;
      2: lane_in = 16'(row);
      default: lane_in = 16'h0002;
    endcase
  endfunction

  function automatic logic [127:0] row_in(input int mode, input int pop);
    row_in = '0;
    for (int c = 0; c < 8; c++) row_in[c*16 +: 16] = lane_in(mode, pop, c);
  endfunction

  function automatic logic [15:0] lane_exp(input int mode, input int row, input int lane);
    case (mode)
      0: lane_exp = 16'h0009;
      1: begin
        if (lane == 0) lane_exp = 16'h7FFF;
`ifdef SFU_RELU_EN
        else if (lane == 1) lane_exp = 16'h0000;
`else
        else if (lane == 1) lane_exp = 16'h8000;
`endif
        else lane_exp = 16'h0009;
      end
      2: lane_exp = 16'(9 * row);
      default: lane_exp = 16'h0012;
    endcase
  endfunction

  function automatic logic [127:0] row_exp(input int mode, input int row);
    row_exp = '0;
    for (int c = 0; c < 8; c++) row_exp[c*16 +: 16] = lane_exp(mode, row, c);
  endfunction

  task automatic run_tile(input int mode, input bit stall, input bit extra_start,
                          input int rst_after, input string tag);
    int pop, cyc, wr_cnt, done_cnt, done_cyc, last_pop, rd_bad, busy_bad, order_bad;
    bit stop, did_rst;
    logic [127:0] mem [16];
    pop = 0; cyc = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_pop = -1;
    rd_bad = 0; busy_bad = 0; order_bad = 0; stop = 0; did_rst = 0;
    for (int r = 0; r < 16; r++) mem[r] = '1;
    while (!stop && cyc < 1000) begin
      @(negedge clk);
      if (rst_after >= 0 && pop == rst_after) begin
        sfu_start = 1'b0;
        ofifo_valid = 1'b0;
        reset = 1'b1;
        #1;
        check({tag, "_rst_cen"}, 128'(op_cen), 128'(1'b1));
        check({tag, "_rst_busy"}, 128'(sfu_busy), 128'(1'b0));
        check({tag, "_rst_rd"}, 128'(ofifo_rd), 128'(1'b0));
        check({tag, "_rst_nowr"}, 128'(wr_cnt), 128'(0));
        @(negedge clk);
        check({tag, "_rst_hold_wen"}, 128'(op_wen), 128'(1'b1));
        reset = 1'b0;
        did_rst = 1;
        stop = 1;
      end else begin
        sfu_start   = (cyc == 0) || (extra_start && (cyc == 60 || cyc == 150));
        ofifo_valid = stall ? (cyc % 2 == 0) : 1'b1;
        ofifo_data  = ofifo_valid ? row_in(mode, pop) : {4{$urandom()}};
        #1;
        if (ofifo_rd && !ofifo_valid) rd_bad++;
        if (cyc == 0 && ofifo_rd) rd_bad++;
        if (ofifo_rd) begin
          pop++;
          last_pop = cyc;
        end
        if (!op_cen && !op_wen) begin
          if (op_addr != 4'(wr_cnt)) order_bad++;
          mem[op_addr] = op_d;
          wr_cnt++;
        end
        if (sfu_done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (cyc >= 1 && done_cyc < 0 && !sfu_busy) busy_bad++;
        if (done_cyc >= 0 && cyc >= done_cyc + 10) stop = 1;
        cyc++;
      end
    end
    sfu_start = 1'b0;
    ofifo_valid = 1'b0;
    if (!did_rst) begin
      check({tag, "_done_seen"}, 128'(done_cyc >= 0), 128'(1'b1));
      check({tag, "_done_cyc"}, 128'(done_cyc), 128'(stall ? 305 : 161));
      check({tag, "_last_pop"}, 128'(last_pop), 128'(stall ? 288 : 144));
      check({tag, "_pops"}, 128'(pop), 128'(144));
      check({tag, "_writes"}, 128'(wr_cnt), 128'(16));
      check({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
      check({tag, "_wr_order"}, 128'(order_bad), 128'(0));
      check({tag, "_rd_gating"}, 128'(rd_bad), 128'(0));
      check({tag, "_busy_hold"}, 128'(busy_bad), 128'(0));
      check({tag, "_busy_end"}, 128'(sfu_busy), 128'(1'b0));
      check({tag, "_cen_end"}, 128'(op_cen), 128'(1'b1));
      for (int r = 0; r < 16; r++) check($sformatf("%s_row%0d", tag, r), mem[r], row_exp(mode, r));
    end
  endtask

  initial begin
    reset = 1'b1;
    sfu_start = 1'b0;
    ofifo_valid = 1'b0;
    ofifo_data = '0;
    repeat (2) @(negedge clk);
    check("reset_cen", 128'(op_cen), 128'(1'b1));
    check("reset_wen", 128'(op_wen), 128'(1'b1));
    check("reset_addr", 128'(op_addr), 128'(0));
    check("reset_d", op_d, 128'(0));
    check("reset_busy", 128'(sfu_busy), 128'(1'b0));
    check("reset_done", 128'(sfu_done), 128'(1'b0));
    reset = 1'b0;
    ofifo_valid = 1'b1;
    ofifo_data = row_in(0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("idle_no_rd", 128'(ofifo_rd), 128'(1'b0));
    check("idle_busy", 128'(sfu_busy), 128'(1'b0));

    run_tile(0, 1'b0, 1'b0, -1, "basic");
    run_tile(1, 1'b0, 1'b0, -1, "sat");
    run_tile(0, 1'b1, 1'b0, -1, "stall");
    run_tile(0, 1'b0, 1'b1, -1, "ign_start");
    run_tile(0, 1'b0, 1'b0, 50, "midrst");
    run_tile(2, 1'b0, 1'b0, -1, "rowidx");
    run_tile(3, 1'b0, 1'b0, -1, "b2b");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
